icache_direct_mapped: RTL and testbench
=======================================

Name: icache_direct_mapped

Overview:
- Direct-mapped, single-word-per-line instruction cache between the instruction-fetch unit and the memory controller's ICache port.
- Serves fetch requests from the fetch unit on a hit.
- On a miss, issues one 4-byte fetch to the memory controller, fills the line and returns the instruction.
- Supports a pipeline clear that discards an in-flight miss response without corrupting the cache.

Parameters:
- INDEX_WIDTH, 6, log2 of line count (64 lines). Index = pc[INDEX_WIDTH+1:2]; tag = pc[31:INDEX_WIDTH+2].

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset; asynchronous, active-high.
- rdy_in  input  1  global enable; when low, all state holds.
- clear  input  1  pipeline flush (mispredict).
- if_req  input  1  fetch request, valid only when if_ready=1.
- if_pc  input  32  fetch address; bits [1:0] ignored.
- if_ready  output  1  combinational; 1 iff state==IDLE.
- if_valid  output  1  registered one-cycle pulse: if_inst valid.
- if_inst  output  32  instruction returned.
- ic_mem_ask  output  1  registered miss request to the memory controller.
- ic_mem_addr  output  32  registered miss address, {pc[31:2],2'b00}.
- ic_mem_valid  input  1  one-cycle pulse: ic_mem_inst valid.
- ic_mem_inst  input  32  fetched word, little-endian assembled.

Behaviour:
- Reset (async): all line valid bits=0; state=IDLE; if_valid=0, if_inst=0, ic_mem_ask=0, ic_mem_addr=0; discard flag=0. Tag/data arrays need no reset.
- Reset mid-miss: abort immediately, back to IDLE. No fill; the memory controller resets too.
- rdy_in=0: no register or array changes; outputs hold.
- if_valid defaults to 0 every enabled cycle unless set below.
- State IDLE, if_req=1 and clear=0:
  - Hit (line valid and tags match): next cycle if_valid=1 and if_inst=line data; stay IDLE. Back-to-back hits give one per cycle.
  - Miss: next cycle ic_mem_ask=1, ic_mem_addr={if_pc[31:2],2'b00}, state=MISS; latch index and tag.
- State IDLE, clear=1: request ignored, no lookup.
- State MISS:
  - ic_mem_ask and ic_mem_addr are held stable until ic_mem_valid; the controller may delay arbitrarily because it serves the LSB first.
  - On ic_mem_valid=1: write data, tag and valid=1 to the latched index, replacing any previous line. Next cycle ic_mem_ask=0 and state=IDLE.
  - If discard=0 and clear=0 that cycle: also if_valid=1 and if_inst=ic_mem_inst.
- Deassertion timing: ic_mem_ask drops the cycle after the ic_mem_valid pulse. This coincides with the controller's pause cycle, so no duplicate fetch is issued.
- clear in MISS: set discard=1 and keep waiting; the line is still filled with correct data, but no if_valid is produced. discard is cleared on return to IDLE.
- clear in the same cycle as ic_mem_valid: line is filled, no if_valid.
- clear in the same cycle as a hit's if_valid: the already-registered pulse is not retracted. The fetch unit is responsible for ignoring it.
- Latency:
  - Hit: 1 cycle from request to if_valid.
  - Miss: 1 cycle to ic_mem_ask, then controller latency, then 1 cycle from ic_mem_valid to if_valid.
- ic_mem_valid in IDLE: ignored.

Optional Feature:
- ICACHE_STAT_EN defined: adds output ports hit_cnt[31:0] and miss_cnt[31:0].
  - Both reset to 0.
  - hit_cnt increments on each accepted hit lookup; miss_cnt increments on each miss entry.
  - Both wrap at 2^32 and freeze when rdy_in=0.
- ICACHE_STAT_EN undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold miss: if_pc=0x00000000; controller returns 0x00000013 five cycles after ask.
  - Required: ask=1 with addr=0x0 held through the wait.
  - if_valid pulse with if_inst=0x00000013 one cycle after ic_mem_valid; ask=0 that same cycle.
- Hit: repeat if_pc=0x00000000 and then 0x00000002.
  - Required: if_valid next cycle with 0x00000013 each time; ic_mem_ask stays 0.
- Conflict eviction (INDEX_WIDTH=6): fetch 0x00000100, returning 0x00100093.
  - Required: miss, index 0 replaced.
  - A later fetch of 0x00000000 misses again, with ask addr=0x0.
- Clear during miss: assert clear two cycles after ask.
  - Required: no if_valid on return; line still filled.
  - An immediate re-fetch of the same pc hits next cycle.
- rdy_in low for 3 cycles mid-miss with ic_mem_valid held low.
  - Required: state, ask and addr unchanged; completion proceeds normally after rdy_in returns high.
- Async reset pulse mid-miss, between clock edges.
  - Required: ask=0 and if_valid=0 immediately; fetch of 0x0 afterwards misses.
  - With ICACHE_STAT_EN defined: counters read 0.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped
// Direct-mapped, one-word-per-line instruction cache between the fetch unit
// and the memory controller's ICache port.
// Optional build macro: ICACHE_STAT_EN adds the hit_cnt / miss_cnt output ports.
//
// Handshake:
// - The fetch side presents if_req/if_pc, and the request is taken only while if_ready=1.
// - The answer is a one-cycle if_valid pulse, 1 cycle after a hit or 1 cycle after ic_mem_valid on a miss.
// - The memory side holds ic_mem_ask/ic_mem_addr stable until the one-cycle ic_mem_valid pulse.
// - ic_mem_ask drops on the cycle after that pulse.
//
// dbg_state_o exposes the FSM state (0 = IDLE, 1 = MISS).

module icache_direct_mapped #(
   parameter int INDEX_WIDTH = 6
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic        if_req,
   input  logic [31:0] if_pc,
   output logic        if_ready,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic        ic_mem_ask,
   output logic [31:0] ic_mem_addr,
   input  logic        ic_mem_valid,
   input  logic [31:0] ic_mem_inst,
`ifdef ICACHE_STAT_EN
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt,
`endif
   output logic        dbg_state_o
);

   localparam int LINES = 1 << INDEX_WIDTH;
   localparam int TAG_W = 32 - INDEX_WIDTH - 2;

   typedef enum logic {S_IDLE = 1'b0, S_MISS = 1'b1} state_t;

   state_t state_q, state_d;

   // Line storage: only the valid bits need a reset value.
   logic [LINES-1:0]       valid_q;
   logic [TAG_W-1:0]       tag_mem_q  [LINES];
   logic [31:0]            data_mem_q [LINES];

   logic                   if_valid_q, if_valid_d;
   logic [31:0]            if_inst_q, if_inst_d;
   logic                   ask_q, ask_d;
   logic [31:0]            addr_q, addr_d;
   logic                   discard_q, discard_d;
   logic [INDEX_WIDTH-1:0] miss_idx_q, miss_idx_d;
   logic [TAG_W-1:0]       miss_tag_q, miss_tag_d;

   logic [INDEX_WIDTH-1:0] req_idx;
   logic [TAG_W-1:0]       req_tag;
   logic                   lookup_en;
   logic                   hit;
   logic                   miss;
   logic                   fill_en;
   logic                   unused_pc_lsbs;

   assign req_idx        = if_pc[INDEX_WIDTH+1:2];
   assign req_tag        = if_pc[31:INDEX_WIDTH+2];
   assign unused_pc_lsbs = ^if_pc[1:0];

   // A lookup happens only for a real, unflushed request while idle and enabled.
   assign lookup_en = rdy_in && (state_q == S_IDLE) && if_req && !clear;
   assign hit       = lookup_en && valid_q[req_idx] && (tag_mem_q[req_idx] == req_tag);
   assign miss      = lookup_en && !hit;
   assign fill_en   = rdy_in && (state_q == S_MISS) && ic_mem_valid;

   assign if_ready    = (state_q == S_IDLE);
   assign if_valid    = if_valid_q;
   assign if_inst     = if_inst_q;
   assign ic_mem_ask  = ask_q;
   assign ic_mem_addr = addr_q;
   assign dbg_state_o = state_q;

   // State register; holds while rdy_in is low, aborts to IDLE on reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
      end else if (rdy_in) begin
         state_q <= state_d;
      end
   end

   // Next state: enter MISS on a lookup miss, leave when the refill word arrives.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (miss)         state_d = S_MISS;
         S_MISS:  if (ic_mem_valid) state_d = S_IDLE;
         default:                   state_d = S_IDLE;
      endcase
   end

   // Outputs and miss bookkeeping: if_valid is a pulse, and everything else holds by default.
   always_comb begin
      if_valid_d = 1'b0;
      if_inst_d  = if_inst_q;
      ask_d      = ask_q;
      addr_d     = addr_q;
      discard_d  = discard_q;
      miss_idx_d = miss_idx_q;
      miss_tag_d = miss_tag_q;
      case (state_q)
         S_IDLE: begin
            discard_d = 1'b0;
            if (hit) begin
               if_valid_d = 1'b1;
               if_inst_d  = data_mem_q[req_idx];
            end else if (miss) begin
               ask_d      = 1'b1;
               addr_d     = {if_pc[31:2], 2'b00};
               miss_idx_d = req_idx;
               miss_tag_d = req_tag;
            end
         end
         S_MISS: begin
            // A flush during the wait still lets the fill complete, but the
            // returned word is no longer wanted by the fetch unit.
            if (clear) discard_d = 1'b1;
            if (ic_mem_valid) begin
               ask_d     = 1'b0;
               discard_d = 1'b0;
               if (!discard_q && !clear) begin
                  if_valid_d = 1'b1;
                  if_inst_d  = ic_mem_inst;
               end
            end
         end
         default: ;
      endcase
   end

   // Output and bookkeeping registers, frozen while rdy_in is low.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         if_valid_q <= 1'b0;
         if_inst_q  <= '0;
         ask_q      <= 1'b0;
         addr_q     <= '0;
         discard_q  <= 1'b0;
         miss_idx_q <= '0;
         miss_tag_q <= '0;
      end else if (rdy_in) begin
         if_valid_q <= if_valid_d;
         if_inst_q  <= if_inst_d;
         ask_q      <= ask_d;
         addr_q     <= addr_d;
         discard_q  <= discard_d;
         miss_idx_q <= miss_idx_d;
         miss_tag_q <= miss_tag_d;
      end
   end

   // Valid bits: cleared by reset, and set when a refill lands.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         valid_q <= '0;
      end else if (fill_en) begin
         valid_q[miss_idx_q] <= 1'b1;
      end
   end

   // Tag and data arrays: written on refill only, and never reset.
   always_ff @(posedge clk_in) begin
      if (fill_en) begin
         tag_mem_q[miss_idx_q]  <= miss_tag_q;
         data_mem_q[miss_idx_q] <= ic_mem_inst;
      end
   end

`ifdef ICACHE_STAT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

   // Event counters: count accepted lookups, wrap naturally, and freeze with rdy_in.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at that same point.

module tb_icache_direct_mapped;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        ic_mem_ask;
  logic [31:0] ic_mem_addr;
  logic        ic_mem_valid;
  logic [31:0] ic_mem_inst;
  logic        dbg_state_o;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  icache_direct_mapped #(.INDEX_WIDTH(6)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear        (clear),
    .if_req       (if_req),
    .if_pc        (if_pc),
    .if_ready     (if_ready),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .ic_mem_ask   (ic_mem_ask),
    .ic_mem_addr  (ic_mem_addr),
    .ic_mem_valid (ic_mem_valid),
    .ic_mem_inst  (ic_mem_inst),
`ifdef ICACHE_STAT_EN
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
`endif
    .dbg_state_o  (dbg_state_o)
  );

  // Clock and reset.
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Drivers.
  task automatic issue_req(input logic [31:0] pc);
    if_req = 1'b1;
    if_pc  = pc;
    step();
    if_req = 1'b0;
  endtask

  task automatic mem_return(input logic [31:0] data, input logic with_clear);
    ic_mem_valid = 1'b1;
    ic_mem_inst  = data;
    clear        = with_clear;
    step();
    ic_mem_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; if_req = 1'b0; if_pc = '0;
    ic_mem_valid = 1'b0; ic_mem_inst = '0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    step();
    n_checks++; if (if_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", if_ready); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", if_valid); else n_pass++;
    n_checks++; if (if_inst !== 32'h0) $display("FAIL reset_if_inst: got %h want 0", if_inst); else n_pass++;
    n_checks++; if (ic_mem_ask !== 1'b0) $display("FAIL reset_ask: got %b want 0", ic_mem_ask); else n_pass++;
    n_checks++; if (ic_mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", ic_mem_addr); else n_pass++;
`ifdef ICACHE_STAT_EN
    n_checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) $display("FAIL reset_cnt: got %0d/%0d want 0/0", hit_cnt, miss_cnt); else n_pass++;
`endif
  endtask

  task automatic test_cold_miss();
    issue_req(32'h0000_0000);
    n_checks++; if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h0) $display("FAIL cold_ask: got ask=%b addr=%h want 1/0", ic_mem_ask, ic_mem_addr); else n_pass++;
    n_checks++; if (if_ready !== 1'b0 || dbg_state_o !== 1'b1) $display("FAIL cold_state: got ready=%b st=%b want 0/1", if_ready, dbg_state_o); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h0 || if_valid !== 1'b0) $display("FAIL cold_hold%0d: got ask=%b addr=%h v=%b want 1/0/0", i, ic_mem_ask, ic_mem_addr, if_valid); else n_pass++;
    end
    mem_return(32'h0000_0013, 1'b0);
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0013) $display("FAIL cold_resp: got v=%b inst=%h want 1/00000013", if_valid, if_inst); else n_pass++;
    n_checks++; if (ic_mem_ask !== 1'b0 || if_ready !== 1'b1) $display("FAIL cold_ask_drop: got ask=%b ready=%b want 0/1", ic_mem_ask, if_ready); else n_pass++;
    step();
    n_checks++; if (if_valid !== 1'b0) $display("FAIL cold_pulse: got %b want 0", if_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    if_req = 1'b1;
    if_pc  = 32'h0000_0000;
    step();
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0013 || ic_mem_ask !== 1'b0) $display("FAIL hit0: got v=%b inst=%h ask=%b want 1/00000013/0", if_valid, if_inst, ic_mem_ask); else n_pass++;
    if_pc = 32'h0000_0002;
    step();
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0013 || ic_mem_ask !== 1'b0) $display("FAIL hit2: got v=%b inst=%h ask=%b want 1/00000013/0", if_valid, if_inst, ic_mem_ask); else n_pass++;
    if_req = 1'b0;
    step();
    n_checks++; if (if_valid !== 1'b0) $display("FAIL hit_idle: got %b want 0", if_valid); else n_pass++;
  endtask

  task automatic test_conflict();
    issue_req(32'h0000_0100);
    n_checks++; if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h0000_0100) $display("FAIL conf_ask: got ask=%b addr=%h want 1/00000100", ic_mem_ask, ic_mem_addr); else n_pass++;
    step();
    mem_return(32'h0010_0093, 1'b0);
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h0010_0093) $display("FAIL conf_resp: got v=%b inst=%h want 1/00100093", if_valid, if_inst); else n_pass++;
    issue_req(32'h0000_0000);
    n_checks++; if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h0 || if_valid !== 1'b0) $display("FAIL conf_evict: got ask=%b addr=%h v=%b want 1/0/0", ic_mem_ask, ic_mem_addr, if_valid); else n_pass++;
    mem_return(32'h0000_0013, 1'b0);
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0013) $display("FAIL conf_refill: got v=%b inst=%h want 1/00000013", if_valid, if_inst); else n_pass++;
  endtask

  task automatic test_clear_miss();
    issue_req(32'h0000_0040);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++; if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h0000_0040) $display("FAIL clr_hold: got ask=%b addr=%h want 1/00000040", ic_mem_ask, ic_mem_addr); else n_pass++;
    step();
    mem_return(32'hDEAD_BEEF, 1'b0);
    n_checks++; if (if_valid !== 1'b0 || ic_mem_ask !== 1'b0 || if_ready !== 1'b1) $display("FAIL clr_discard: got v=%b ask=%b ready=%b want 0/0/1", if_valid, ic_mem_ask, if_ready); else n_pass++;
    issue_req(32'h0000_0040);
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'hDEAD_BEEF || ic_mem_ask !== 1'b0) $display("FAIL clr_refetch: got v=%b inst=%h ask=%b want 1/deadbeef/0", if_valid, if_inst, ic_mem_ask); else n_pass++;
    // A flush that lands on the same cycle as the refill word.
    issue_req(32'h0000_0080);
    step();
    mem_return(32'h1234_5678, 1'b1);
    n_checks++; if (if_valid !== 1'b0 || if_ready !== 1'b1) $display("FAIL clr_same: got v=%b ready=%b want 0/1", if_valid, if_ready); else n_pass++;
    issue_req(32'h0000_0080);
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h1234_5678) $display("FAIL clr_same_fill: got v=%b inst=%h want 1/12345678", if_valid, if_inst); else n_pass++;
  endtask

  task automatic test_rdy_stall();
    issue_req(32'h0000_00C0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h0000_00C0 || dbg_state_o !== 1'b1) $display("FAIL rdy_hold%0d: got ask=%b addr=%h st=%b want 1/000000c0/1", i, ic_mem_ask, ic_mem_addr, dbg_state_o); else n_pass++;
    end
    rdy_in = 1'b1;
    step();
    mem_return(32'h1111_1111, 1'b0);
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h1111_1111 || ic_mem_ask !== 1'b0) $display("FAIL rdy_resume: got v=%b inst=%h ask=%b want 1/11111111/0", if_valid, if_inst, ic_mem_ask); else n_pass++;
  endtask

  task automatic test_async_reset();
    issue_req(32'h0000_0200);
    step();
    #2 rst_in = 1'b1;
    #1;
    n_checks++; if (ic_mem_ask !== 1'b0 || if_valid !== 1'b0 || if_ready !== 1'b1) $display("FAIL areset_now: got ask=%b v=%b ready=%b want 0/0/1", ic_mem_ask, if_valid, if_ready); else n_pass++;
`ifdef ICACHE_STAT_EN
    n_checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) $display("FAIL areset_cnt: got %0d/%0d want 0/0", hit_cnt, miss_cnt); else n_pass++;
`endif
    #1 rst_in = 1'b0;
    step();
    issue_req(32'h0000_0000);
    n_checks++; if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h0 || if_valid !== 1'b0) $display("FAIL areset_miss: got ask=%b addr=%h v=%b want 1/0/0", ic_mem_ask, ic_mem_addr, if_valid); else n_pass++;
    mem_return(32'h0000_0013, 1'b0);
    n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0013) $display("FAIL areset_fill: got v=%b inst=%h want 1/00000013", if_valid, if_inst); else n_pass++;
`ifdef ICACHE_STAT_EN
    n_checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd1) $display("FAIL areset_cnt_after: got %0d/%0d want 0/1", hit_cnt, miss_cnt); else n_pass++;
`endif
  endtask

  // Sequence and final report.
  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_clear_miss();
    test_rdy_stall();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
